// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit path and its baud generator.
// Latency: n/a (types, constants and a pure parity function only).
// Backpressure: n/a.
package uart_pkg;

    // Transmit FSM states, in the order they are visited during one frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;
    localparam int MAX_DATA_BITS = 9;

    // Shared with the baud-rate tick generator so both sides agree on the bit period.
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;

    // Parity over a zero-extended data word. Unused upper bits must be zero,
    // so the XOR reduce only sees the real data bits.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Purpose: UART transmitter; one TxData word per TxValid/TxReady handshake, sent LSB-first as start/data/parity/stop.
// Latency: start bit goes out on the first BaudTick after the handshake (a tick in the handshake cycle is ignored);
//          back-to-back frames follow with no idle gap. Backpressure: TxReady high only in IDLE or on the final stop tick.
// Ports: CLK/Reset_n (async active-low), BaudTick (one-cycle bit strobe), TxData/TxValid/TxReady (input handshake),
//        Tx (serial line, idle high), TxBusy (frame in progress), TxDone (one-cycle pulse at frame end).
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int STOP_BITS  = DEF_STOP_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 BaudTick,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxValid,
    output logic                 TxReady,
    output logic                 Tx,
    output logic                 TxBusy,
    output logic                 TxDone
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    tx_state_e              state_q,    state_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [3:0]             bit_idx_q,  bit_idx_d;
    logic [1:0]             stop_cnt_q, stop_cnt_d;
    logic                   parity_q,   parity_d;
    logic                   tx_q,       tx_d;
    logic                   done_q,     done_d;

    logic                     last_stop_tick;
    logic                     xfer;
    logic [MAX_DATA_BITS-1:0] data_ext;

    // The tick that closes the last stop bit is also the slot for the next
    // frame's start bit, so a new word can be taken right then.
    assign last_stop_tick = (state_q == ST_STOP) && BaudTick && (stop_cnt_q == LAST_STOP);
    assign TxReady        = (state_q == ST_IDLE) || last_stop_tick;
    assign xfer           = TxValid && TxReady;

    always_comb begin
        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = TxData;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        if (xfer) begin
            shift_d  = TxData;
            parity_d = parity_bit(data_ext, PARITY_ODD != 0);
        end

        case (state_q)
            ST_IDLE: begin
                // Wait for the next tick before the start bit so it lasts a full bit period.
                if (xfer) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (BaudTick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (BaudTick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (BaudTick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        stop_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (BaudTick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (BaudTick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_d     = 1'b1;
                        stop_cnt_d = '0;
                        if (xfer) begin
                            // Back-to-back: start bit of the next frame begins now.
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign TxBusy = (state_q != ST_IDLE);
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: self-checking bench for uart_tx; four instances cover 8N1, 8E1, 8O1 and 8N2.
// Latency: n/a. Backpressure: stimulus holds TxValid until the reference model accepts the word.
module tb_uart_tx;

    localparam int N = 4;

    logic         CLK      = 1'b0;
    logic         Reset_n  = 1'b0;
    logic         BaudTick = 1'b0;
    bit           tick_en  = 1'b1;
    int           tick_cnt = 0;
    int           tick_no  = 0;

    logic [7:0]   tx_data [N];
    logic [N-1:0] tx_valid = '0;
    logic [N-1:0] tx_ready, tx_line, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;

    // Reference model: expected serial line, busy/done and the frame bits still to go out.
    logic [15:0]  m_bits [N];
    int           m_left [N];
    int           acc_cnt [N];
    logic [N-1:0] m_active = '0;
    logic [N-1:0] m_line   = '1;
    logic [N-1:0] m_done   = '0;

    uart_tx u0 (.CLK(CLK), .Reset_n(Reset_n), .BaudTick(BaudTick), .TxData(tx_data[0]),
                .TxValid(tx_valid[0]), .TxReady(tx_ready[0]), .Tx(tx_line[0]),
                .TxBusy(tx_busy[0]), .TxDone(tx_done[0]));
    uart_tx #(.PARITY_EN(1)) u1 (.CLK(CLK), .Reset_n(Reset_n), .BaudTick(BaudTick),
                .TxData(tx_data[1]), .TxValid(tx_valid[1]), .TxReady(tx_ready[1]),
                .Tx(tx_line[1]), .TxBusy(tx_busy[1]), .TxDone(tx_done[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.CLK(CLK), .Reset_n(Reset_n),
                .BaudTick(BaudTick), .TxData(tx_data[2]), .TxValid(tx_valid[2]),
                .TxReady(tx_ready[2]), .Tx(tx_line[2]), .TxBusy(tx_busy[2]), .TxDone(tx_done[2]));
    uart_tx #(.STOP_BITS(2)) u3 (.CLK(CLK), .Reset_n(Reset_n), .BaudTick(BaudTick),
                .TxData(tx_data[3]), .TxValid(tx_valid[3]), .TxReady(tx_ready[3]),
                .Tx(tx_line[3]), .TxBusy(tx_busy[3]), .TxDone(tx_done[3]));

    always #5 CLK = ~CLK;

    function automatic int cfg_pe(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_po(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Line values in time order (bit 0 first): start, data LSB-first, parity, stop bits.
    function automatic logic [15:0] make_frame(input int i, input logic [7:0] d, output int len);
        logic [15:0] f;
        int          n;
        f = '0;
        n = 1;
        for (int b = 0; b < 8; b++) begin
            f[n] = d[b];
            n++;
        end
        if (cfg_pe(i) == 1) begin
            f[n] = (($countones(d) % 2) == 1) ^ (cfg_po(i) == 1);
            n++;
        end
        for (int s = 0; s < cfg_sb(i); s++) begin
            f[n] = 1'b1;
            n++;
        end
        len = n;
        return f;
    endfunction

    // Ready when idle, or on the tick that ends a frame whose bits have all gone out.
    function automatic logic m_ready(input int i);
        return !m_active[i] || (BaudTick && m_left[i] == 0);
    endfunction

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Baud strobe: one CLK every 4, unless paused.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (tick_en) begin
                tick_cnt = (tick_cnt + 1) % 4;
                BaudTick = (tick_cnt == 0);
            end else begin
                BaudTick = 1'b0;
            end
        end
    end

    // Model update on each clock edge (or asynchronously on reset).
    initial begin
        for (int i = 0; i < N; i++) begin
            m_bits[i]  = '0;
            m_left[i]  = 0;
            acc_cnt[i] = 0;
        end
        forever begin
            @(posedge CLK or negedge Reset_n);
            if (!Reset_n) begin
                m_active = '0;
                m_line   = '1;
                m_done   = '0;
                for (int i = 0; i < N; i++) begin
                    m_left[i] = 0;
                    m_bits[i] = '0;
                end
            end else begin
                if (BaudTick) tick_no++;
                for (int i = 0; i < N; i++) begin
                    logic acc;
                    logic ended;
                    int   len;
                    acc       = tx_valid[i] && m_ready(i);
                    ended     = 1'b0;
                    m_done[i] = 1'b0;
                    if (BaudTick && m_active[i]) begin
                        if (m_left[i] > 0) begin
                            m_line[i] = m_bits[i][0];
                            m_bits[i] = m_bits[i] >> 1;
                            m_left[i]--;
                        end else begin
                            m_done[i]   = 1'b1;
                            m_active[i] = 1'b0;
                            ended       = 1'b1;
                        end
                    end
                    if (acc) begin
                        m_bits[i]   = make_frame(i, tx_data[i], len);
                        m_left[i]   = len;
                        m_active[i] = 1'b1;
                        acc_cnt[i]++;
                        if (ended) begin
                            m_line[i] = m_bits[i][0];
                            m_bits[i] = m_bits[i] >> 1;
                            m_left[i]--;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (Reset_n) begin
                for (int i = 0; i < N; i++) begin
                    chk("tx",    i, tx_line[i],  m_line[i]);
                    chk("busy",  i, tx_busy[i],  m_active[i]);
                    chk("done",  i, tx_done[i],  m_done[i]);
                    chk("ready", i, tx_ready[i], m_ready(i));
                end
            end
        end
    end

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge CLK);
            if (BaudTick) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: no BaudTick within 200 cycles");
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit keep);
        int c0;
        bit ok;
        c0          = acc_cnt[i];
        ok          = 1'b0;
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge CLK);
            #1;
            if (acc_cnt[i] != c0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake[%0d]: accepted=0, expected 1", i);
        end
        if (!keep) tx_valid[i] = 1'b0;
    endtask

    // exp is written in time order, first line value in the MSB position.
    task automatic expect_frame(input int i, input string name, input logic [15:0] exp, input int n);
        for (int b = 0; b < n; b++) begin
            wait_tick();
            @(negedge CLK);
            chk(name, b, tx_line[i], exp[n-1-b]);
        end
        wait_tick();
        @(negedge CLK);
        chk({name, "_done"}, i, tx_done[i], 1'b1);
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 400 && m_active[i]; k++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int dt [2];
        for (int i = 0; i < N; i++) tx_data[i] = 8'h00;

        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_tx",    i, tx_line[i],  1'b1);
            chk("rst_busy",  i, tx_busy[i],  1'b0);
            chk("rst_done",  i, tx_done[i],  1'b0);
            chk("rst_ready", i, tx_ready[i], 1'b1);
        end
        #2 Reset_n = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // 8N1 0xA5
        send(0, 8'hA5, 1'b0);
        expect_frame(0, "n81_a5", 16'b0101001011, 10);
        wait_idle(0);

        // Parity: even 0xA5 -> 0, odd 0xA5 -> 1, even 0x01 -> 1
        send(1, 8'hA5, 1'b0);
        expect_frame(1, "even_a5", 16'b01010010101, 11);
        send(2, 8'hA5, 1'b0);
        expect_frame(2, "odd_a5", 16'b01010010111, 11);
        send(1, 8'h01, 1'b0);
        expect_frame(1, "even_01", 16'b01000000011, 11);
        wait_idle(1);

        // Back-to-back 0x55 then 0x0F, TxValid held high throughout
        send(0, 8'h55, 1'b1);
        tx_data[0] = 8'h0F;
        dn = 0;
        fork
            begin
                for (int b = 0; b < 21; b++) begin
                    logic [19:0] exp_b2b;
                    exp_b2b = 20'b0101010101_0111100001;
                    wait_tick();
                    @(negedge CLK);
                    if (b < 20) chk("b2b_tx", b, tx_line[0], exp_b2b[19-b]);
                    if (tx_done[0] && dn < 2) begin
                        dt[dn] = tick_no;
                        dn++;
                    end
                end
            end
            begin
                int c0;
                c0 = acc_cnt[0];
                for (int k = 0; k < 200 && acc_cnt[0] == c0; k++) begin
                    @(posedge CLK);
                    #1;
                end
                tx_valid[0] = 1'b0;
            end
        join
        chk("b2b_done_cnt", 0, 16'(dn), 16'd2);
        if (dn == 2) chk("b2b_done_gap", 0, 16'(dt[1] - dt[0]), 16'd10);
        wait_idle(0);

        // Handshake on a BaudTick cycle: that tick is ignored; mid-frame TxData/TxValid ignored
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #2;
            if (BaudTick) break;
        end
        send(0, 8'h3C, 1'b0);
        @(negedge CLK);
        chk("sync_tick_tx", 0, tx_line[0], 1'b1);
        fork
            expect_frame(0, "sync_3c", 16'b0001111001, 10);
            begin
                repeat (14) @(posedge CLK);
                #1;
                tx_data[0]  = 8'hFF;
                tx_valid[0] = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                tx_valid[0] = 1'b0;
                tx_data[0]  = 8'h00;
            end
        join
        wait_idle(0);

        // Two stop bits, 0xFF: line high for 10 ticks after the start bit
        send(3, 8'hFF, 1'b0);
        expect_frame(3, "n82_ff", 16'b01111111111, 11);
        wait_idle(3);

        // BaudTick paused mid-frame: line and busy hold
        send(0, 8'hC3, 1'b0);
        repeat (3) wait_tick();
        #1 tick_en = 1'b0;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("hold_tx",   0, tx_line[0], 1'b1);
        chk("hold_busy", 0, tx_busy[0], 1'b1);
        tick_en = 1'b1;
        wait_idle(0);

        // Reset mid-DATA aborts at once, then a clean frame follows
        send(0, 8'hA5, 1'b0);
        repeat (4) wait_tick();
        @(posedge CLK);
        #3 Reset_n = 1'b0;
        #1;
        chk("abort_tx",   0, tx_line[0], 1'b1);
        chk("abort_busy", 0, tx_busy[0], 1'b0);
        chk("abort_done", 0, tx_done[0], 1'b0);
        repeat (2) @(posedge CLK);
        #3 Reset_n = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        send(0, 8'h3C, 1'b0);
        expect_frame(0, "post_rst", 16'b0001111001, 10);
        wait_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
